// File: rtl/alu_param_if.sv
// Bus between the controller and alu_param: the request side and the result/status side.
// The controller holds the master modport and the ALU holds the slave modport.
interface alu_param_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
);
    logic             alu_ena;
    logic [OP_W-1:0]  opcode;
    logic [WIDTH-1:0] accum;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic [3:0]       flags;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output alu_ena, opcode, accum, data,
        input  alu_out, zero, flags, busy, done, illegal
    );

    modport slave (
        input  alu_ena, opcode, accum, data,
        output alu_out, zero, flags, busy, done, illegal
    );
endinterface

// File: rtl/alu_param.sv
// Parametrised ALU with registered N/Z/C/V flags and a WIDTH-cycle shift-add multiplier.
// Single-cycle ops are resolved at the accept edge; MUL runs through a two-state FSM.
module alu_param #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_param_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_HLT = 4'b0000;
    localparam logic [3:0] OP_SKZ = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_STO = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_ADC = 4'b1101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [3:0]           flags_q, flags_d;
    logic                 done_q, done_d;
    logic                 illegal_q, illegal_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     a_s;
    logic [WIDTH-1:0]     b_s;
    logic [3:0]           op_s;
    logic                 legal_hi_s;
    logic                 accept_s;
    logic                 cin_s;
    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sub_s;
    logic                 add_ovf_s;
    logic                 sub_ovf_s;
    logic [2*WIDTH-1:0]   prod_next_s;

    // Packs {N,Z,C,V} for a result with the given carry and overflow.
    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res,
                                              input logic c, input logic v);
        pack_flags = {res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v};
    endfunction

    assign a_s        = bus.accum;
    assign b_s        = bus.data;
    assign op_s       = bus.opcode[3:0];
    assign legal_hi_s = ((bus.opcode >> 3'd4) == {OP_W{1'b0}});
    assign accept_s   = bus.alu_ena && (state_q == ST_IDLE);
    assign cin_s      = (op_s == OP_ADC) ? flags_q[1] : 1'b0;

    assign add_s = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, cin_s};
    assign sub_s = {1'b0, a_s} - {1'b0, b_s};
    // Sub's top bit is the borrow: it is set exactly when A < B unsigned.
    assign add_ovf_s = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (add_s[WIDTH-1] != a_s[WIDTH-1]);
    assign sub_ovf_s = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (sub_s[WIDTH-1] != a_s[WIDTH-1]);

    assign prod_next_s = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    // Next-state, result and flag selection for both FSM states.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    done_d = 1'b1;
                    if (!legal_hi_s) begin
                        illegal_d = 1'b1;
                    end else begin
                        case (op_s)
                            OP_HLT, OP_SKZ, OP_STO, OP_JMP: out_d = a_s;
                            OP_LDA: out_d = b_s;
                            OP_ADD, OP_ADC: begin
                                out_d   = add_s[WIDTH-1:0];
                                flags_d = pack_flags(add_s[WIDTH-1:0], add_s[WIDTH], add_ovf_s);
                            end
                            OP_SUB: begin
                                out_d   = sub_s[WIDTH-1:0];
                                flags_d = pack_flags(sub_s[WIDTH-1:0], sub_s[WIDTH], sub_ovf_s);
                            end
                            OP_AND: begin
                                out_d   = a_s & b_s;
                                flags_d = pack_flags(a_s & b_s, 1'b0, 1'b0);
                            end
                            OP_OR: begin
                                out_d   = a_s | b_s;
                                flags_d = pack_flags(a_s | b_s, 1'b0, 1'b0);
                            end
                            OP_XOR: begin
                                out_d   = a_s ^ b_s;
                                flags_d = pack_flags(a_s ^ b_s, 1'b0, 1'b0);
                            end
                            OP_SHL: begin
                                out_d   = {a_s[WIDTH-2:0], 1'b0};
                                flags_d = pack_flags({a_s[WIDTH-2:0], 1'b0}, a_s[WIDTH-1], 1'b0);
                            end
                            OP_SHR: begin
                                out_d   = {1'b0, a_s[WIDTH-1:1]};
                                flags_d = pack_flags({1'b0, a_s[WIDTH-1:1]}, a_s[0], 1'b0);
                            end
                            OP_MUL: begin
                                done_d   = 1'b0;
                                state_d  = ST_MUL;
                                mcand_d  = {{WIDTH{1'b0}}, a_s};
                                mplier_d = b_s;
                                prod_d   = {(2*WIDTH){1'b0}};
                                cnt_d    = {CNT_W{1'b0}};
                            end
                            default: illegal_d = 1'b1;
                        endcase
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_MUL: begin
                prod_d   = prod_next_s;
                mcand_d  = mcand_q << 1'b1;
                mplier_d = mplier_q >> 1'b1;
                cnt_d    = cnt_q + CNT_ONE;
                // The last iteration commits the product it is completing this edge.
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    out_d   = prod_next_s[WIDTH-1:0];
                    flags_d = pack_flags(prod_next_s[WIDTH-1:0],
                                         |prod_next_s[2*WIDTH-1:WIDTH], 1'b0);
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_q     <= {WIDTH{1'b0}};
            flags_q   <= 4'b0000;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            mcand_q   <= {(2*WIDTH){1'b0}};
            prod_q    <= {(2*WIDTH){1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.alu_out = out_q;
    assign bus.flags   = flags_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.busy    = (state_q == ST_MUL);
    assign bus.zero    = (bus.accum == {WIDTH{1'b0}});
endmodule

// File: tb/tb_alu_param.sv
// Directed and random bench for alu_param (WIDTH=8, OP_W=5) against an arithmetic reference model.
module tb_alu_param;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [7:0] exp_out;
    logic [3:0] exp_flags;
    logic       exp_ill;

    alu_param_if #(.WIDTH(8), .OP_W(5)) bus ();

    alu_param #(.WIDTH(8), .OP_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference: results from plain integer arithmetic, signed range tests for V.
    task automatic model(input logic [4:0] op, input int a, input int b);
        int r, full, sr, cin;
        bit upd;
        logic c, v;
        upd = 1'b1; c = 1'b0; v = 1'b0; r = int'(exp_out); exp_ill = 1'b0;
        if (op > 5'd13) begin
            exp_ill = 1'b1;
            upd = 1'b0;
        end else begin
            case (int'(op))
                0, 1, 6, 7: begin r = a; upd = 1'b0; end
                5: begin r = b; upd = 1'b0; end
                2, 13: begin
                    cin = (op == 5'd13) ? int'(exp_flags[1]) : 0;
                    full = a + b + cin;
                    r = full % 256; c = (full > 255);
                    sr = sgn(a) + sgn(b) + cin; v = (sr > 127) || (sr < -128);
                end
                8: begin
                    r = (a - b + 256) % 256; c = (a < b);
                    sr = sgn(a) - sgn(b); v = (sr > 127) || (sr < -128);
                end
                3: r = a & b;
                9: r = a | b;
                4: r = a ^ b;
                10: begin r = (a * 2) % 256; c = (a >= 128); end
                11: begin r = a / 2; c = (a % 2) == 1; end
                12: begin full = a * b; r = full % 256; c = (full > 255); end
                default: upd = 1'b0;
            endcase
        end
        exp_out = 8'(r);
        if (upd) exp_flags = {(r >= 128), (r == 0), c, v};
    endtask

    // Presents one op; leaves alu_ena high so single-cycle ops can run back to back.
    task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input bit inject);
        logic [7:0] old_out;
        int lat;
        bit busy_ok;
        bus.alu_ena = 1'b1; bus.opcode = op; bus.accum = a; bus.data = b;
        @(posedge clk); #1;
        old_out = exp_out;
        model(op, int'(a), int'(b));
        if (op == 5'd12) begin
            lat = 0; busy_ok = 1'b1;
            while (bus.done !== 1'b1 && lat < 40) begin
                if (bus.busy !== 1'b1 || bus.alu_out !== old_out) busy_ok = 1'b0;
                if (inject && lat == 2) begin
                    bus.alu_ena = 1'b1; bus.opcode = 5'd2; bus.accum = 8'($urandom);
                end else begin
                    bus.alu_ena = 1'b0;
                end
                @(posedge clk); #1;
                lat++;
            end
            check("mul_latency", lat, 8);
            check("mul_busy_hold", busy_ok, 1'b1);
            check("mul_done", bus.done, 1'b1);
            check("mul_busy_end", bus.busy, 1'b0);
            check("mul_out", bus.alu_out, exp_out);
            check("mul_flags", bus.flags, exp_flags);
        end else begin
            check("done", bus.done, 1'b1);
            check("illegal", bus.illegal, exp_ill);
            check("busy", bus.busy, 1'b0);
            check("out", bus.alu_out, exp_out);
            check("flags", bus.flags, exp_flags);
        end
    endtask

    task automatic idle();
        bus.alu_ena = 1'b0;
        @(posedge clk); #1;
        check("idle_done", bus.done, 1'b0);
        check("idle_illegal", bus.illegal, 1'b0);
    endtask

    initial begin
        bit seen_done;
        logic [4:0] rop;
        clk = 1'b0; rst_n = 1'b0; checks = 0; failures = 0;
        exp_out = 8'h00; exp_flags = 4'h0; exp_ill = 1'b0;
        bus.alu_ena = 1'b0; bus.opcode = 5'd0; bus.accum = 8'h33; bus.data = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", bus.alu_out, 8'h00);
        check("rst_flags", bus.flags, 4'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_illegal", bus.illegal, 1'b0);

        rst_n = 1'b1;
        issue(5'd4, 8'($urandom), 8'($urandom), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", bus.alu_out, 8'h00);
        check("midrst_flags", bus.flags, 4'h0);
        check("midrst_done", bus.done, 1'b0);
        exp_out = 8'h00; exp_flags = 4'h0;
        bus.alu_ena = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(5'd2, 8'h12, 8'h34, 1'b0);
        check("add_4600", {bus.alu_out, bus.flags}, 12'h460);
        issue(5'd5, 8'($urandom), 8'h5A, 1'b0);
        issue(5'd7, 8'h07, 8'($urandom), 1'b0);
        issue(5'd2, 8'h7F, 8'h01, 1'b0);
        check("ovf_flags", bus.flags, 4'b1001);
        issue(5'd2, 8'hFF, 8'h01, 1'b0);
        check("carry_flags", bus.flags, 4'b0110);
        issue(5'd13, 8'h10, 8'h20, 1'b0);
        check("adc_out", bus.alu_out, 8'h31);
        issue(5'd8, 8'h03, 8'h05, 1'b0);
        check("sub_out", bus.alu_out, 8'hFE);
        issue(5'd10, 8'h81, 8'h00, 1'b0);
        check("shl_out", {bus.alu_out, bus.flags[1]}, 9'h005);
        issue(5'd11, 8'h01, 8'h00, 1'b0);
        check("shr_flags", bus.flags, 4'b0110);
        idle();

        issue(5'd12, 8'h0D, 8'h0B, 1'b1);
        check("mul_8f", bus.alu_out, 8'h8F);
        issue(5'd12, 8'h20, 8'h10, 1'b0);
        check("mul_zc", bus.flags[2:1], 2'b11);
        idle();

        bus.alu_ena = 1'b1; bus.opcode = 5'd12; bus.accum = 8'h5B; bus.data = 8'hC3;
        @(posedge clk); #1;
        bus.alu_ena = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mulrst_busy", bus.busy, 1'b0);
        check("mulrst_out", bus.alu_out, 8'h00);
        exp_out = 8'h00; exp_flags = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("mulrst_nodone", seen_done, 1'b0);
        check("mulrst_flags", bus.flags, 4'h0);

        bus.accum = 8'h00;
        #1 check("zero_hi", bus.zero, 1'b1);
        bus.accum = 8'h40;
        #1 check("zero_lo", bus.zero, 1'b0);

        issue(5'd2, 8'h9C, 8'hA7, 1'b0);
        issue(5'h0E, 8'($urandom), 8'($urandom), 1'b0);
        check("ill_pulse", {bus.illegal, bus.done}, 2'b11);
        idle();
        issue(5'h12, 8'($urandom), 8'($urandom), 1'b0);
        check("ill_upper", bus.illegal, 1'b1);
        idle();

        for (int i = 0; i < 60; i++) begin
            rop = 5'($urandom_range(0, 17));
            issue(rop, 8'($urandom), 8'($urandom), 1'b0);
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
